// File: rtl/rst_domain_sequencer_if.sv
// Reset-sequencer bundle: restart request and per-domain ready in, per-domain resets and status out.
// Purely structural; the master side is the sequencer, the slave side is the reset consumers.
interface rst_domain_sequencer_if #(
    parameter int NUM_DOMAINS = 3
);
    logic                   sw_rst_req;
    logic [NUM_DOMAINS-1:0] dom_ready;
    logic [NUM_DOMAINS-1:0] dom_rst_n;
    logic                   seq_busy;
    logic                   seq_done;
    logic [NUM_DOMAINS-1:0] dom_err;

    modport master (
        input  sw_rst_req, dom_ready,
        output dom_rst_n, seq_busy, seq_done, dom_err
    );

    modport slave (
        output sw_rst_req, dom_ready,
        input  dom_rst_n, seq_busy, seq_done, dom_err
    );
endinterface

// File: rtl/rst_domain_sequencer.sv
// Releases per-domain active-low resets in index order; first release SYNC_STAGES+HOLD_CYCLES+1 edges after reset.
// No backpressure: a missing dom_ready only stalls the sequence until GAP/timeout rules let it advance.
module rst_domain_sequencer #(
    parameter int NUM_DOMAINS    = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   async_rst_n,
    rst_domain_sequencer_if.master seq_if
);
    localparam int MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_ALL = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(MAX_ALL + 1);
    localparam int IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] GAP_MIN  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] TO_END   = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_HOLD,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_rst_n_q, dom_rst_n_d;
    logic [NUM_DOMAINS-1:0] dom_err_q, dom_err_d;
    logic [SYNC_STAGES-1:0] sync_q;

    logic          rst_sync;
    logic [CW-1:0] cnt_inc;
    logic [IW-1:0] idx_nxt;
    logic          rdy_cur;
    logic          ready_hit;
    logic          timeout_hit;

    // Deassertion synchronizer: clears instantly, releases after SYNC_STAGES edges.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];
    assign cnt_inc  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);
    assign idx_nxt  = idx_q + IW'(1);

    always_comb begin
        rdy_cur = 1'b0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (IW'(i) == idx_q) begin
                rdy_cur = seq_if.dom_ready[i] & dom_rst_n_q[i];
            end
        end
    end

    assign ready_hit   = (cnt_q >= GAP_MIN) && rdy_cur;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_END);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        dom_rst_n_d = dom_rst_n_q;
        dom_err_d   = dom_err_q;

        if ((state_q != ST_RESET) && seq_if.sw_rst_req) begin
            state_d     = ST_HOLD;
            cnt_d       = '0;
            idx_d       = '0;
            dom_rst_n_d = '0;
            dom_err_d   = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (rst_sync) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_END) begin
                        dom_rst_n_d[0] = 1'b1;
                        idx_d          = '0;
                        cnt_d          = '0;
                        state_d        = ST_WAIT;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_WAIT: begin
                    if (ready_hit || timeout_hit) begin
                        // Ready takes precedence when it lands on the timeout cycle.
                        if (!ready_hit) begin
                            for (int i = 0; i < NUM_DOMAINS; i++) begin
                                if (IW'(i) == idx_q) dom_err_d[i] = 1'b1;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            for (int i = 1; i < NUM_DOMAINS; i++) begin
                                if (IW'(i) == idx_nxt) dom_rst_n_d[i] = 1'b1;
                            end
                            idx_d = idx_nxt;
                            cnt_d = '0;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            idx_q       <= '0;
            dom_rst_n_q <= '0;
            dom_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dom_rst_n_q <= dom_rst_n_d;
            dom_err_q   <= dom_err_d;
        end
    end

    assign seq_if.dom_rst_n = dom_rst_n_q;
    assign seq_if.dom_err   = dom_err_q;
    assign seq_if.seq_done  = (state_q == ST_DONE);
    assign seq_if.seq_busy  = (state_q != ST_DONE);
endmodule

// File: tb/tb_rst_domain_sequencer.sv
// Bench for rst_domain_sequencer: fixed scenario table, hand-written reset corner cases,
// and randomized ready delays checked against a release-time arithmetic model.
module tb_rst_domain_sequencer;
    localparam int ND      = 3;
    localparam int SYNC    = 2;
    localparam int HOLD    = 4;
    localparam int GAP     = 2;
    localparam int TO      = 16;
    localparam int NEVER   = 1000;
    localparam int BUDGET  = 150;

    logic clk;
    logic async_rst_n;
    int   checks;
    int   errors;

    rst_domain_sequencer_if #(.NUM_DOMAINS(ND)) sif ();

    rst_domain_sequencer #(
        .NUM_DOMAINS   (ND),
        .SYNC_STAGES   (SYNC),
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .async_rst_n(async_rst_n),
        .seq_if     (sif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         pre;
        int         d0, d1, d2;
        int         r1, r2, dn;
        logic [2:0] err;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drives dom_ready reactively: before release per pre mode (0/1/random), after release
    // low for d cycles then high. Records release edges relative to the starting edge.
    task automatic observe(input int pre, input int d0, input int d1, input int d2,
                           output int r0, output int r1, output int r2, output int dn,
                           output logic [2:0] err, output int flags);
        int         d[3];
        int         r[3];
        int         e;
        bit         fin;
        logic [2:0] rdy;
        d[0] = d0; d[1] = d1; d[2] = d2;
        r = '{-1, -1, -1};
        dn = -1; err = '0; flags = 0; e = 0; fin = 1'b0; rdy = '0;
        for (int t = 0; t < BUDGET && !fin; t++) begin
            for (int i = 0; i < 3; i++) begin
                if (r[i] < 0) begin
                    case (pre)
                        0:       rdy[i] = 1'b0;
                        1:       rdy[i] = 1'b1;
                        default: rdy[i] = 1'($urandom_range(0, 1));
                    endcase
                end else begin
                    rdy[i] = ((e - r[i]) >= d[i]);
                end
            end
            sif.dom_ready = rdy;
            @(posedge clk);
            #1;
            e++;
            for (int i = 0; i < 3; i++) begin
                if (sif.dom_rst_n[i] && r[i] < 0) r[i] = e;
                if (!sif.dom_rst_n[i] && r[i] >= 0) flags++;
            end
            if (sif.seq_done) begin
                fin = 1'b1;
                dn  = e;
                err = sif.dom_err;
                if (sif.seq_busy) flags++;
            end else if (!sif.seq_busy) begin
                flags++;
            end
        end
        r0 = r[0]; r1 = r[1]; r2 = r[2];
    endtask

    task automatic run_sw(input string tag, input int pre, input int d0, input int d1, input int d2,
                          output int r0, output int r1, output int r2, output int dn,
                          output logic [2:0] err, output int flags);
        sif.sw_rst_req = 1'b1;
        @(posedge clk);
        #1;
        sif.sw_rst_req = 1'b0;
        check({tag, "_swclr_rst_n"}, sif.dom_rst_n, 0);
        check({tag, "_swclr_err"}, sif.dom_err, 0);
        observe(pre, d0, d1, d2, r0, r1, r2, dn, err, flags);
    endtask

    task automatic check_run(input string tag, input int r0, input int r1, input int r2, input int dn,
                             input logic [2:0] err, input int flags,
                             input int e0, input int e1, input int e2, input int edn, input logic [2:0] eerr);
        check({tag, "_r0"}, r0, e0);
        check({tag, "_r1"}, r1, e1);
        check({tag, "_r2"}, r2, e2);
        check({tag, "_done"}, dn, edn);
        check({tag, "_err"}, err, eerr);
        check({tag, "_glitch"}, flags, 0);
    endtask

    initial begin
        int         r0, r1, r2, dn, flags;
        logic [2:0] err;

        checks = 0;
        errors = 0;
        async_rst_n    = 1'b0;
        sif.sw_rst_req = 1'b0;
        sif.dom_ready  = '0;

        //          pre d0     d1     d2     r1  r2  done err
        tbl[0] = '{1,  0,     0,     0,     7,  9,  11, 3'b000};
        tbl[1] = '{0,  0,     NEVER, 0,     7,  23, 25, 3'b010};
        tbl[2] = '{0,  5,     0,     0,     11, 13, 15, 3'b000};
        tbl[3] = '{1,  0,     15,    0,     7,  23, 25, 3'b000};
        tbl[4] = '{1,  0,     16,    0,     7,  23, 25, 3'b010};
        tbl[5] = '{0,  NEVER, NEVER, NEVER, 21, 37, 53, 3'b111};
        tbl[6] = '{0,  0,     0,     16,    7,  9,  25, 3'b100};
        tbl[7] = '{0,  3,     1,     0,     9,  11, 13, 3'b000};

        repeat (3) @(posedge clk);
        #1;
        check("rst_dom_rst_n", sif.dom_rst_n, 0);
        check("rst_busy", sif.seq_busy, 1);
        check("rst_done", sif.seq_done, 0);
        check("rst_err", sif.dom_err, 0);

        // Power-up with dom_ready tied high; edge index 0 is the first edge seeing reset released.
        @(posedge clk);
        #3;
        async_rst_n = 1'b1;
        @(posedge clk);
        #1;
        observe(1, 0, 0, 0, r0, r1, r2, dn, err, flags);
        check_run("pwr", r0, r1, r2, dn, err, flags, 7, 9, 11, 13, 3'b000);

        for (int v = 0; v < 8; v++) begin
            run_sw($sformatf("tbl%0d", v), tbl[v].pre, tbl[v].d0, tbl[v].d1, tbl[v].d2,
                   r0, r1, r2, dn, err, flags);
            check_run($sformatf("tbl%0d", v), r0, r1, r2, dn, err, flags,
                      HOLD + 1, tbl[v].r1, tbl[v].r2, tbl[v].dn, tbl[v].err);
        end

        // A second restart while still in HOLD restarts the hold count.
        sif.sw_rst_req = 1'b1;
        @(posedge clk);
        #1;
        sif.sw_rst_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold_mid_rst_n", sif.dom_rst_n, 0);
        run_sw("hold_restart", 0, 0, 0, 0, r0, r1, r2, dn, err, flags);
        check_run("hold_restart", r0, r1, r2, dn, err, flags, 5, 7, 9, 11, 3'b000);

        // Async reset glitch while waiting on domain 1.
        sif.dom_ready  = 3'b001;
        sif.sw_rst_req = 1'b1;
        @(posedge clk);
        #1;
        sif.sw_rst_req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("midwait_rst_n", sif.dom_rst_n, 3'b011);
        #2;
        async_rst_n = 1'b0;
        #1;
        check("glitch_rst_n", sif.dom_rst_n, 0);
        check("glitch_busy", sif.seq_busy, 1);
        check("glitch_done", sif.seq_done, 0);
        check("glitch_err", sif.dom_err, 0);
        async_rst_n = 1'b1;
        @(posedge clk);
        #1;
        observe(1, 0, 0, 0, r0, r1, r2, dn, err, flags);
        check_run("glitch_restart", r0, r1, r2, dn, err, flags, 7, 9, 11, 13, 3'b000);

        // Randomized ready delays against release-time arithmetic.
        for (int n = 0; n < 25; n++) begin
            int         d[3];
            int         er[3];
            int         edn;
            int         first;
            int         k;
            logic [2:0] eerr;
            for (int i = 0; i < 3; i++) begin
                d[i] = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(0, 20));
            end
            eerr  = '0;
            er[0] = HOLD + 1;
            edn   = 0;
            for (int i = 0; i < 3; i++) begin
                first = d[i] + 1;
                if (first > TO) begin
                    k       = TO;
                    eerr[i] = 1'b1;
                end else begin
                    k = (first > GAP) ? first : GAP;
                end
                if (i < 2) er[i+1] = er[i] + k;
                else       edn     = er[i] + k;
            end
            run_sw($sformatf("rnd%0d", n), 2, d[0], d[1], d[2], r0, r1, r2, dn, err, flags);
            check_run($sformatf("rnd%0d", n), r0, r1, r2, dn, err, flags,
                      er[0], er[1], er[2], edn, eerr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
